// File: rtl/spi_cntrl.sv
// -----------------------------------------------------------------------------
// spi_cntrl -- single-byte SPI master (mode 0), MSB first, optional chip-select
// hold for multi-byte transactions.
//
// Configuration macro:
//   SPI_CNTRL_CS_GAP_EN  When defined, SPI_CS is kept high for HALF cycles
//                        (state GAP) after it rises, and start is ignored
//                        during that time.
//
// Parameters:
//   CLK_FREQUENCY   system clock frequency in Hz
//   SCLK_FREQUENCY  SPI clock frequency in Hz
//   HALF = CLK_FREQUENCY / (2*SCLK_FREQUENCY) clk cycles per SCLK phase (>= 2)
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          request to transfer one byte (ignored while busy)
//   data_to_send   byte shifted out MSB first, sampled when start is accepted
//   hold_cs        keep SPI_CS low after the current byte completes
//   SPI_MISO       serial data from the subunit
//   SPI_SCLK       SPI clock, idle low
//   SPI_MOSI       serial data to the subunit, 1 when idle
//   SPI_CS         active-low chip select
//   busy           high while a byte is being shifted
//   done           one-cycle pulse when a byte completes
//   data_received  last byte captured from SPI_MISO
// -----------------------------------------------------------------------------
module spi_cntrl #(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_to_send,
    input  logic       hold_cs,
    input  logic       SPI_MISO,
    output logic       SPI_SCLK,
    output logic       SPI_MOSI,
    output logic       SPI_CS,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_received
);

    localparam int HALF  = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
    // Guard the width so an illegal HALF reaches the $fatal below cleanly.
    localparam int CNT_W = (HALF < 2) ? 1 : $clog2(HALF + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

    if (HALF < 2) begin : g_half_chk
        $fatal(1, "spi_cntrl: HALF = %0d, must be at least 2", HALF);
    end

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rx_out_q, rx_out_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_out_d   = rx_out_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    tx_d       = data_to_send;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                    cs_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = LOW;
                end
            end

            LOW: begin
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    sclk_d     = 1'b1;
                    state_d    = HIGH;
                end else begin
                    half_cnt_d = half_cnt_q + CNT_W'(1);
                end
            end

            HIGH: begin
                // Sample MISO one clk after SCLK rose; the subunit drives
                // on the falling edge so the line is stable here.
                if (half_cnt_q == '0) begin
                    rx_d = {rx_q[6:0], SPI_MISO};
                end
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    sclk_d     = 1'b0;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        rx_out_d  = rx_q;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        if (hold_cs) begin
                            state_d = HOLD;
                        end else begin
                            cs_d = 1'b1;
`ifdef SPI_CNTRL_CS_GAP_EN
                            state_d = GAP;
`else
                            state_d = IDLE;
`endif
                        end
                    end else begin
                        tx_d      = {tx_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = LOW;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + CNT_W'(1);
                end
            end

            HOLD: begin
                cs_d   = 1'b0;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                // A new byte wins over releasing CS; CS then releases after it.
                if (start) begin
                    tx_d       = data_to_send;
                    half_cnt_d = '0;
                    bit_cnt_d  = '0;
                    busy_d     = 1'b1;
                    state_d    = LOW;
                end else if (!hold_cs) begin
                    cs_d    = 1'b1;
`ifdef SPI_CNTRL_CS_GAP_EN
                    half_cnt_d = '0;
                    state_d    = GAP;
`else
                    state_d    = IDLE;
`endif
                end
            end

            GAP: begin
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                busy_d = 1'b0;
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    half_cnt_d = half_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                half_cnt_d = '0;
                bit_cnt_d  = '0;
                cs_d       = 1'b1;
                sclk_d     = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_out_q   <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_out_q   <= rx_out_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign SPI_CS        = cs_q;
    assign SPI_SCLK      = sclk_q;
    assign SPI_MOSI      = cs_q ? 1'b1 : tx_q[7];
    assign busy          = busy_q;
    assign done          = done_q;
    assign data_received = rx_out_q;

endmodule

// File: tb/tb_spi_cntrl.sv
// -----------------------------------------------------------------------------
// tb_spi_cntrl -- self-checking bench for spi_cntrl with HALF = 4.
// A behavioural SPI subunit captures MOSI on SCLK rising edges and drives
// MISO MSB first, changing on SCLK falling edges. Expected bytes and the
// start->done latency come from queues and plain arithmetic.
// -----------------------------------------------------------------------------
module tb_spi_cntrl;

    localparam int CLK_F   = 8_000_000;
    localparam int SCLK_F  = 1_000_000;
    localparam int HALF    = CLK_F / (2 * SCLK_F);
    localparam int EXP_LAT = 1 + 16 * HALF;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data_to_send;
    logic       hold_cs;
    logic       SPI_MISO;
    logic       SPI_SCLK;
    logic       SPI_MOSI;
    logic       SPI_CS;
    logic       busy;
    logic       done;
    logic [7:0] data_received;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    spi_cntrl #(
        .CLK_FREQUENCY (CLK_F),
        .SCLK_FREQUENCY(SCLK_F)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .data_to_send (data_to_send),
        .hold_cs      (hold_cs),
        .SPI_MISO     (SPI_MISO),
        .SPI_SCLK     (SPI_SCLK),
        .SPI_MOSI     (SPI_MOSI),
        .SPI_CS       (SPI_CS),
        .busy         (busy),
        .done         (done),
        .data_received(data_received)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- behavioural SPI subunit ----------------
    logic [7:0] sub_val = 8'h00;
    logic [7:0] sub_sh  = 8'h00;
    int         sub_bits   = 0;
    int         miso_idx   = 0;
    int         sclk_rises = 0;
    int         cs_rises   = 0;
    int         done_cnt   = 0;
    logic [7:0] sub_q[$];

    assign SPI_MISO = SPI_CS ? 1'b0 : sub_val[7 - miso_idx];

    always @(posedge SPI_CS) begin
        miso_idx = 0;
        sub_bits = 0;
        cs_rises++;
    end

    always @(posedge SPI_SCLK) begin
        if (!SPI_CS) begin
            sub_sh = {sub_sh[6:0], SPI_MOSI};
            sub_bits++;
            sclk_rises++;
            if (sub_bits == 8) begin
                sub_q.push_back(sub_sh);
                sub_bits = 0;
            end
        end
    end

    always @(negedge SPI_SCLK) begin
        if (!SPI_CS) miso_idx = (miso_idx + 1) % 8;
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (done === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    // Issue one byte; returns at the negedge where done is high.
    task automatic do_byte(input logic [7:0] d, input logic hold, output int lat);
        int t0;
        @(negedge clk);
        data_to_send = d;
        hold_cs      = hold;
        start        = 1'b1;
        t0           = cyc;
        @(negedge clk);
        start = 1'b0;
        check("cs_low_after_start", SPI_CS, 1'b0);
        check("busy_after_start", busy, 1'b1);
        wait_done(t0, lat);
    endtask

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic [7:0] d, m;
    int         lat, t0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        hold_cs = 1'b0;
        data_to_send = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cs", SPI_CS, 1'b1);
        check("rst_sclk", SPI_SCLK, 1'b0);
        check("rst_mosi", SPI_MOSI, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dr", data_received, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Directed byte: 0xA5 out, subunit answers 0x3C.
        sub_val = 8'h3C;
        sub_q.delete();
        done_cnt = 0;
        do_byte(8'hA5, 1'b0, lat);
        check("a5_latency", lat, EXP_LAT);
        @(negedge clk);
        check("a5_cs_high", SPI_CS, 1'b1);
        check("a5_dr", data_received, 8'h3C);
        check("a5_sub_cnt", sub_q.size(), 1);
        if (sub_q.size() > 0) check("a5_sub_byte", sub_q.pop_front(), 8'hA5);
        check("a5_done_cnt", done_cnt, 1);

        // Randomized single bytes, extremes first.
        for (int i = 0; i < 8; i++) begin
            d = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'($urandom);
            m = (i == 0) ? 8'hFF : (i == 1) ? 8'h00 : 8'($urandom);
            exp_tx.push_back(d);
            exp_rx.push_back(m);
            sub_val = m;
            do_byte(d, 1'b0, lat);
            check("rnd_latency", lat, EXP_LAT);
            @(negedge clk);
            check("rnd_dr", data_received, exp_rx.pop_front());
            if (sub_q.size() > 0) check("rnd_sub_byte", sub_q.pop_front(), exp_tx.pop_front());
            else check("rnd_sub_missing", 0, 1);
        end

        // Two bytes under one chip select; CS release requested with the second start.
        sclk_rises = 0;
        cs_rises   = 0;
        done_cnt   = 0;
        sub_q.delete();
        sub_val = 8'h5A;
        do_byte(8'h12, 1'b1, lat);
        check("hold1_latency", lat, EXP_LAT);
        check("hold1_cs_low", SPI_CS, 1'b0);
        check("hold1_dr", data_received, 8'h5A);
        sub_val = 8'hC3;
        do_byte(8'h34, 1'b0, lat);
        check("hold2_latency", lat, EXP_LAT);
        @(negedge clk);
        check("hold_cs_rises", cs_rises, 1);
        check("hold_sclk_rises", sclk_rises, 16);
        check("hold_done_cnt", done_cnt, 2);
        check("hold2_dr", data_received, 8'hC3);
        check("hold_sub_cnt", sub_q.size(), 2);
        if (sub_q.size() == 2) begin
            check("hold_sub_b0", sub_q.pop_front(), 8'h12);
            check("hold_sub_b1", sub_q.pop_front(), 8'h34);
        end

        // Hold then release without a new byte.
        sub_q.delete();
        do_byte(8'h69, 1'b1, lat);
        @(negedge clk);
        check("hold_idle_cs", SPI_CS, 1'b0);
        check("hold_idle_busy", busy, 1'b0);
        hold_cs = 1'b0;
        @(negedge clk);
        check("release_cs", SPI_CS, 1'b1);

        // Reset in the middle of a byte.
        @(negedge clk);
        done_cnt   = 0;
        sclk_rises = 0;
        data_to_send = 8'h96;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && sclk_rises < 4; i++) @(negedge clk);
        check("mid_sclk_rises", sclk_rises, 4);
        rst = 1'b1;
        #1;
        check("mid_rst_cs", SPI_CS, 1'b1);
        check("mid_rst_sclk", SPI_SCLK, 1'b0);
        check("mid_rst_mosi", SPI_MOSI, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        miso_idx = 0;
        sub_bits = 0;
        repeat (EXP_LAT + 5) @(negedge clk);
        check("mid_no_done", done_cnt, 0);
        check("mid_dr_zero", data_received, 8'h00);
        check("mid_cs_idle", SPI_CS, 1'b1);

        // start held high for a whole byte: exactly one byte, next starts after done.
        sub_q.delete();
        done_cnt = 0;
        sub_val = 8'h81;
        @(negedge clk);
        data_to_send = 8'hFF;
        start = 1'b1;
        t0 = cyc;
        wait_done(t0, lat);
        check("held_latency", lat, EXP_LAT);
        check("held_sub_cnt", sub_q.size(), 1);
        @(negedge clk);
        check("held_done_cnt", done_cnt, 1);
        check("held_second_cs", SPI_CS, 1'b0);
        check("held_second_busy", busy, 1'b1);
        start = 1'b0;
        t0 = cyc;
        wait_done(t0, lat);
        check("held_sub_cnt2", sub_q.size(), 2);

        // Start asserted the cycle after done.
        @(negedge clk);
        data_to_send = 8'h3E;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef SPI_CNTRL_CS_GAP_EN
        check("gap_cs_still_high", SPI_CS, 1'b1);
`else
        check("nogap_cs_low", SPI_CS, 1'b0);
`endif
        t0 = cyc;
        wait_done(t0, lat);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
